// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the multiplexed 7-segment driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Width of the digit index; a single-digit display still gets one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high segment pattern, with forced blank.
// Output polarity is handled by the instantiating top level.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    // Table lookup, overridden by blanking.
    always_comb begin
        pattern = blank ? SEG_BLANK : HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans NUM_DIGITS hex digits onto a multiplexed 7-segment
// display with internal refresh prescaler, per-digit decimal point,
// leading-zero blanking, PWM brightness and frame-synchronous digit update.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int DUTY_BITS        = 3,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              load,
    input  logic [4*NUM_DIGITS-1:0]           digits_in,
    input  logic [NUM_DIGITS-1:0]             dp_in,
    input  logic                              blank_lz,
    input  logic [DUTY_BITS-1:0]              brightness,
    output logic [6:0]                        segments,
    output logic                              dp,
    output logic [NUM_DIGITS-1:0]             anode,
    output logic [idx_width(NUM_DIGITS)-1:0]  scan_idx,
    output logic                              frame_done
);

    localparam int                IDX_W      = idx_width(NUM_DIGITS);
    localparam int                PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic              ANODE_INV  = (ANODE_ACTIVE_LOW != 0);
    localparam logic              SEG_INV    = (SEG_ACTIVE_LOW != 0);

    logic [PRESC_W-1:0]      presc_cnt;
    logic [DUTY_BITS-1:0]    pwm_cnt;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic                    slot_end;
    logic                    frame_wrap;
    logic                    lit;
    logic                    upper_zero;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_select;
    logic [6:0]              cur_pattern;

    // Slot and frame boundaries; frame_done is high in the cycle whose edge wraps the scan.
    assign slot_end   = en && (presc_cnt == PRESC_LAST);
    assign frame_wrap = slot_end && (scan_idx == IDX_LAST);
    assign frame_done = frame_wrap;

    // PWM is compared against the free-running counter so duty is (brightness+1)/2^DUTY_BITS.
    assign lit = en && (pwm_cnt <= brightness);

    // Refresh prescaler, digit index and PWM counter; all freeze while en is low.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            scan_idx  <= '0;
            pwm_cnt   <= '0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + DUTY_BITS'(1);
            if (slot_end) begin
                presc_cnt <= '0;
                scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

    // Pending/active shadows: the display only ever reads the active copy, swapped at frame wrap.
    // NOTE: these shadows are small flop banks, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
            end
            if (frame_wrap) begin
                act_digits <= load ? digits_in : pend_digits;
                act_dp     <= load ? dp_in     : pend_dp;
            end
        end
    end

    // Select the current digit and decide leading-zero blanking from the top digit down.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_select = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_digits[4*i +: 4] == 4'h0);
            if (scan_idx == IDX_W'(i)) begin
                cur_nibble    = act_digits[4*i +: 4];
                cur_dp        = act_dp[i];
                cur_blank     = blank_lz && (i != 0) && upper_zero;
                cur_select[i] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble  (cur_nibble),
        .blank   (cur_blank),
        .pattern (cur_pattern)
    );

    // Registered pin drivers with polarity applied; segments stay driven while the anode is gated off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode    <= {NUM_DIGITS{ANODE_INV}};
            segments <= {7{SEG_INV}};
            dp       <= SEG_INV;
        end else begin
            anode    <= (lit ? cur_select : '0) ^ {NUM_DIGITS{ANODE_INV}};
            segments <= cur_pattern ^ {7{SEG_INV}};
            dp       <= cur_dp ^ SEG_INV;
        end
    end

endmodule
